multi_flag_sync_rx: RTL and testbench

Receive side of a multi-channel toggle-based event synchroniser. Each channel takes a toggle level driven from a foreign clock domain, synchronises it into clk with a parametrised number of stages, and converts each toggle edge into one event. Events are held in a per-channel saturating pending counter, so none are lost while the consumer stalls. Each channel presents events through a valid/ready handshake and reports loss through a sticky overflow flag.

---
 rtl/cdc_pkg.sv | 33 +++
 rtl/toggle_edge_rx.sv | 30 +++
 rtl/multi_flag_sync_rx.sv | 100 ++++++++++
 tb/tb_multi_flag_sync_rx.sv | 329 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cdc_pkg.sv
// rtl/cdc_pkg.sv - shared constants, types and the saturating counter step for the toggle event receiver
package cdc_pkg;

    localparam int MIN_SYNC_STAGES = 2;

    typedef struct packed {
        logic        drop;
        logic [31:0] cnt;
    } sat_t;

    // Increment wins only when not cancelled by a decrement; an increment at max is dropped.
    function automatic sat_t sat_inc_dec(
        input logic [31:0] cnt,
        input logic        inc,
        input logic        dec,
        input logic [31:0] max
    );
        sat_t r;
        r.drop = 1'b0;
        r.cnt  = cnt;
        if (inc && !dec) begin
            if (cnt >= max) begin
                r.drop = 1'b1;
            end else begin
                r.cnt = cnt + 32'd1;
            end
        end else if (dec && !inc && (cnt != 32'd0)) begin
            r.cnt = cnt - 32'd1;
        end
        return r;
    endfunction

endpackage

// File: rtl/toggle_edge_rx.sv
// rtl/toggle_edge_rx.sv - one channel: toggle synchroniser, history flop and gated edge detect
module toggle_edge_rx
    import cdc_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic toggle_i,
    input  logic primed_i,
    output logic edge_o
);

    (* ASYNC_REG = "true" *) logic [SYNC_STAGES-1:0] sync_q;
    logic hist_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= '0;
            hist_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], toggle_i};
            hist_q <= sync_q[SYNC_STAGES-1];
        end
    end

    // History keeps tracking while unprimed so the level at reset release is absorbed.
    assign edge_o = primed_i && (sync_q[SYNC_STAGES-1] != hist_q);

endmodule

// File: rtl/multi_flag_sync_rx.sv
// rtl/multi_flag_sync_rx.sv - multi-channel toggle event receiver with pending counters and sticky overflow
module multi_flag_sync_rx
    import cdc_pkg::*;
#(
    parameter int CHANNELS    = 4,
    parameter int SYNC_STAGES = 2,
    parameter int CNT_W       = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [CHANNELS-1:0] toggle_in,
    output logic [CHANNELS-1:0] out_valid,
    input  logic [CHANNELS-1:0] out_ready,
    output logic [CHANNELS-1:0] overflow,
    input  logic [CHANNELS-1:0] clear_overflow,
    output logic                primed
);

    localparam int              PRIME_W = $clog2(SYNC_STAGES + 2);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    if (CHANNELS < 1) begin : g_bad_channels
        $error("multi_flag_sync_rx: CHANNELS must be >= 1");
    end
    if (SYNC_STAGES < MIN_SYNC_STAGES) begin : g_bad_sync
        $error("multi_flag_sync_rx: SYNC_STAGES below minimum");
    end
    if (CNT_W < 1) begin : g_bad_cnt
        $error("multi_flag_sync_rx: CNT_W must be >= 1");
    end

    logic [PRIME_W-1:0]  prime_cnt_q, prime_cnt_d;
    logic                primed_q, primed_d;
    logic [CHANNELS-1:0] edge_w, pop_w, ov_q, ov_d;
    logic [CNT_W-1:0]    pend_q [CHANNELS];
    logic [CNT_W-1:0]    pend_d [CHANNELS];
    sat_t                res_w  [CHANNELS];
    logic                unused_cnt_hi;

    always_comb begin
        prime_cnt_d = prime_cnt_q;
        primed_d    = primed_q;
        if (!primed_q) begin
            if (prime_cnt_q == PRIME_W'(SYNC_STAGES)) begin
                primed_d = 1'b1;
            end else begin
                prime_cnt_d = prime_cnt_q + PRIME_W'(1);
            end
        end
    end

    for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
        toggle_edge_rx #(
            .SYNC_STAGES(SYNC_STAGES)
        ) u_rx (
            .clk      (clk),
            .rst      (rst),
            .toggle_i (toggle_in[c]),
            .primed_i (primed_q),
            .edge_o   (edge_w[c])
        );
        assign out_valid[c] = |pend_q[c];
    end

    assign pop_w = out_valid & out_ready;

    always_comb begin
        ov_d          = ov_q;
        unused_cnt_hi = 1'b0;
        for (int c = 0; c < CHANNELS; c++) begin
            res_w[c]      = sat_inc_dec(32'(pend_q[c]), edge_w[c], pop_w[c], 32'(CNT_MAX));
            pend_d[c]     = res_w[c].cnt[CNT_W-1:0];
            unused_cnt_hi = unused_cnt_hi ^ (^res_w[c].cnt[31:CNT_W]);
            // A drop in the same cycle as a clear leaves the flag set.
            ov_d[c]       = res_w[c].drop | (ov_q[c] & ~clear_overflow[c]);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            prime_cnt_q <= '0;
            primed_q    <= 1'b0;
            ov_q        <= '0;
            for (int c = 0; c < CHANNELS; c++) begin
                pend_q[c] <= '0;
            end
        end else begin
            prime_cnt_q <= prime_cnt_d;
            primed_q    <= primed_d;
            ov_q        <= ov_d;
            for (int c = 0; c < CHANNELS; c++) begin
                pend_q[c] <= pend_d[c];
            end
        end
    end

    assign overflow = ov_q;
    assign primed   = primed_q;

endmodule

// File: tb/tb_multi_flag_sync_rx.sv
// tb/tb_multi_flag_sync_rx.sv - self-checking bench for multi_flag_sync_rx
module tb_multi_flag_sync_rx;

    localparam int CH    = 4;
    localparam int SYNC  = 2;
    localparam int CNT_W = 4;
    localparam int MAXC  = (1 << CNT_W) - 1;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [CH-1:0] toggle_in = '0;
    logic [CH-1:0] out_ready = '0;
    logic [CH-1:0] clear_overflow = '0;
    logic [CH-1:0] out_valid;
    logic [CH-1:0] overflow;
    logic          primed;

    int n_chk = 0;
    int n_pass = 0;

    int            cyc = 0;
    int            rel = 0;
    int            m_pend [CH];
    bit            m_ov   [CH];
    bit            m_primed;
    logic [CH-1:0] m_prev;
    int            due    [CH][$];
    int            m_hs   [CH];
    int            d_hs   [CH];
    int            last_chg [CH];

    multi_flag_sync_rx #(
        .CHANNELS    (CH),
        .SYNC_STAGES (SYNC),
        .CNT_W       (CNT_W)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .toggle_in      (toggle_in),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .overflow       (overflow),
        .clear_overflow (clear_overflow),
        .primed         (primed)
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    function automatic logic [CH-1:0] mv();
        logic [CH-1:0] v;
        for (int c = 0; c < CH; c++) v[c] = (m_pend[c] > 0);
        return v;
    endfunction

    function automatic logic [CH-1:0] mov();
        logic [CH-1:0] v;
        for (int c = 0; c < CH; c++) v[c] = m_ov[c];
        return v;
    endfunction

    // Reference: a level change seen from the second sample after reset release onwards
    // becomes one event SYNC cycles later; pending/overflow follow the counting rules.
    task automatic model_step();
        cyc++;
        if (rst) begin
            rel      = 0;
            m_prev   = '0;
            m_primed = 1'b0;
            for (int c = 0; c < CH; c++) begin
                m_pend[c] = 0;
                m_ov[c]   = 1'b0;
                due[c].delete();
            end
        end else begin
            rel++;
            for (int c = 0; c < CH; c++) begin
                bit ev, pop, drop;
                ev = (due[c].size() > 0) && (due[c][0] == cyc);
                if (ev) void'(due[c].pop_front());
                pop  = (m_pend[c] > 0) && out_ready[c];
                drop = 1'b0;
                if (rel >= 2 && toggle_in[c] != m_prev[c]) due[c].push_back(cyc + SYNC);
                if (ev && !pop) begin
                    if (m_pend[c] == MAXC) drop = 1'b1;
                    else m_pend[c]++;
                end else if (pop && !ev) begin
                    m_pend[c]--;
                end
                if (pop) m_hs[c]++;
                if (drop) m_ov[c] = 1'b1;
                else if (clear_overflow[c]) m_ov[c] = 1'b0;
            end
            m_prev   = toggle_in;
            m_primed = (rel >= SYNC + 1);
        end
    endtask

    task automatic tick();
        for (int c = 0; c < CH; c++) if (out_valid[c] && out_ready[c]) d_hs[c]++;
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        n_chk++; if (out_valid !== '0) $display("FAIL reset_valid: got %b expected 0000", out_valid); else n_pass++;
        n_chk++; if (overflow !== '0) $display("FAIL reset_overflow: got %b expected 0000", overflow); else n_pass++;
        n_chk++; if (primed !== 1'b0) $display("FAIL reset_primed: got %b expected 0", primed); else n_pass++;
        rst = 1'b0;
        tick();
        tick();
        n_chk++; if (primed !== 1'b0) $display("FAIL prime_early: got %b expected 0", primed); else n_pass++;
        tick();
        n_chk++; if (primed !== 1'b1) $display("FAIL prime_rise: got %b expected 1", primed); else n_pass++;
    endtask

    task automatic test_single();
        int h;
        h = d_hs[0];
        out_ready = 4'b0001;
        toggle_in[0] = 1'b1;
        tick();
        tick();
        n_chk++; if (out_valid !== 4'b0000) $display("FAIL single_early: got %b expected 0000", out_valid); else n_pass++;
        tick();
        n_chk++; if (out_valid !== 4'b0001) $display("FAIL single_valid: got %b expected 0001", out_valid); else n_pass++;
        tick();
        n_chk++; if (out_valid !== 4'b0000) $display("FAIL single_after: got %b expected 0000", out_valid); else n_pass++;
        n_chk++; if (d_hs[0] - h !== 1) $display("FAIL single_hs: got %0d expected 1", d_hs[0] - h); else n_pass++;
    endtask

    task automatic test_backpressure();
        int h;
        out_ready = '0;
        for (int i = 0; i < 5; i++) begin
            toggle_in[1] = ~toggle_in[1];
            tick();
            tick();
        end
        tick();
        tick();
        n_chk++; if (out_valid[1] !== 1'b1) $display("FAIL bp_held: got %b expected 1", out_valid[1]); else n_pass++;
        h = d_hs[1];
        out_ready[1] = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            n_chk++;
            if (out_valid[1] !== (i < 4)) $display("FAIL bp_drain%0d: got %b expected %b", i, out_valid[1], (i < 4));
            else n_pass++;
        end
        tick();
        n_chk++; if (d_hs[1] - h !== 5) $display("FAIL bp_hs: got %0d expected 5", d_hs[1] - h); else n_pass++;
        n_chk++; if (overflow[1] !== 1'b0) $display("FAIL bp_overflow: got %b expected 0", overflow[1]); else n_pass++;
    endtask

    task automatic test_saturation();
        int h;
        out_ready = '0;
        for (int i = 0; i < MAXC; i++) begin
            toggle_in[2] = ~toggle_in[2];
            tick();
            tick();
        end
        tick();
        tick();
        n_chk++; if (overflow[2] !== 1'b0) $display("FAIL sat_full_noov: got %b expected 0", overflow[2]); else n_pass++;
        toggle_in[2] = ~toggle_in[2];
        tick();
        tick();
        clear_overflow[2] = 1'b1;
        tick();
        clear_overflow[2] = 1'b0;
        n_chk++; if (overflow[2] !== 1'b1) $display("FAIL sat_set_beats_clear: got %b expected 1", overflow[2]); else n_pass++;
        toggle_in[2] = ~toggle_in[2];
        tick();
        tick();
        tick();
        h = d_hs[2];
        out_ready[2] = 1'b1;
        for (int i = 0; i < MAXC + 4; i++) tick();
        n_chk++; if (d_hs[2] - h !== MAXC) $display("FAIL sat_hs: got %0d expected %0d", d_hs[2] - h, MAXC); else n_pass++;
        n_chk++; if (out_valid[2] !== 1'b0) $display("FAIL sat_empty: got %b expected 0", out_valid[2]); else n_pass++;
        n_chk++; if (overflow[2] !== 1'b1) $display("FAIL sat_sticky: got %b expected 1", overflow[2]); else n_pass++;
        clear_overflow[2] = 1'b1;
        tick();
        clear_overflow[2] = 1'b0;
        n_chk++; if (overflow[2] !== 1'b0) $display("FAIL sat_clear: got %b expected 0", overflow[2]); else n_pass++;
    endtask

    task automatic test_simultaneous();
        int h;
        out_ready = '0;
        h = d_hs[0];
        toggle_in[0] = ~toggle_in[0];
        tick();
        tick();
        tick();
        toggle_in[0] = ~toggle_in[0];
        tick();
        tick();
        out_ready[0] = 1'b1;
        tick();
        n_chk++; if (out_valid[0] !== 1'b1) $display("FAIL simul_hold: got %b expected 1", out_valid[0]); else n_pass++;
        tick();
        n_chk++; if (out_valid[0] !== 1'b0) $display("FAIL simul_drain: got %b expected 0", out_valid[0]); else n_pass++;
        n_chk++; if (d_hs[0] - h !== 2) $display("FAIL simul_hs: got %0d expected 2", d_hs[0] - h); else n_pass++;
    endtask

    task automatic test_reset_ones();
        int h;
        logic [CH-1:0] any_v;
        out_ready = '1;
        toggle_in = '1;
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        any_v = '0;
        tick();
        any_v |= out_valid;
        tick();
        any_v |= out_valid;
        n_chk++; if (primed !== 1'b0) $display("FAIL ones_prime_early: got %b expected 0", primed); else n_pass++;
        tick();
        n_chk++; if (primed !== 1'b1) $display("FAIL ones_prime_rise: got %b expected 1", primed); else n_pass++;
        for (int i = 0; i < 6; i++) begin
            tick();
            any_v |= out_valid;
        end
        n_chk++; if (any_v !== '0) $display("FAIL ones_spurious: got %b expected 0000", any_v); else n_pass++;
        h = d_hs[3];
        toggle_in[3] = 1'b0;
        for (int i = 0; i < 6; i++) tick();
        n_chk++; if (d_hs[3] - h !== 1) $display("FAIL ones_one_event: got %0d expected 1", d_hs[3] - h); else n_pass++;
    endtask

    task automatic test_reset_mid();
        int h;
        logic [CH-1:0] any_v;
        out_ready = '0;
        for (int i = 0; i < MAXC + 1; i++) begin
            toggle_in[0] = ~toggle_in[0];
            if (i < 3) toggle_in[3] = ~toggle_in[3];
            tick();
            tick();
        end
        tick();
        tick();
        n_chk++; if (out_valid[3] !== 1'b1) $display("FAIL mid_pending: got %b expected 1", out_valid[3]); else n_pass++;
        n_chk++; if (overflow[0] !== 1'b1) $display("FAIL mid_ov_before: got %b expected 1", overflow[0]); else n_pass++;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_chk++; if (out_valid !== '0) $display("FAIL mid_valid: got %b expected 0000", out_valid); else n_pass++;
        n_chk++; if (overflow !== '0) $display("FAIL mid_overflow: got %b expected 0000", overflow); else n_pass++;
        n_chk++; if (primed !== 1'b0) $display("FAIL mid_primed: got %b expected 0", primed); else n_pass++;
        out_ready = '1;
        h = d_hs[0] + d_hs[1] + d_hs[2] + d_hs[3];
        any_v = '0;
        for (int i = 0; i < 8; i++) begin
            tick();
            any_v |= out_valid;
        end
        n_chk++; if (any_v !== '0) $display("FAIL mid_residual_valid: got %b expected 0000", any_v); else n_pass++;
        n_chk++;
        if (d_hs[0] + d_hs[1] + d_hs[2] + d_hs[3] - h !== 0)
            $display("FAIL mid_residual_hs: got %0d expected 0", d_hs[0] + d_hs[1] + d_hs[2] + d_hs[3] - h);
        else n_pass++;
    endtask

    task automatic test_random();
        for (int c = 0; c < CH; c++) last_chg[c] = cyc;
        for (int t = 0; t < 400; t++) begin
            for (int c = 0; c < CH; c++) begin
                if ((cyc + 1 - last_chg[c] >= 2) && ($urandom_range(0, 2) == 0)) begin
                    toggle_in[c] = ~toggle_in[c];
                    last_chg[c]  = cyc + 1;
                end
                out_ready[c]      = ($urandom_range(0, 3) == 0);
                clear_overflow[c] = ($urandom_range(0, 15) == 0);
            end
            tick();
            n_chk++; if (out_valid !== mv()) $display("FAIL rand_valid@%0d: got %b expected %b", cyc, out_valid, mv()); else n_pass++;
            n_chk++; if (overflow !== mov()) $display("FAIL rand_overflow@%0d: got %b expected %b", cyc, overflow, mov()); else n_pass++;
            n_chk++; if (primed !== m_primed) $display("FAIL rand_primed@%0d: got %b expected %b", cyc, primed, m_primed); else n_pass++;
        end
        clear_overflow = '0;
        out_ready = '1;
        for (int i = 0; i < 2 * MAXC + 8; i++) tick();
        for (int c = 0; c < CH; c++) begin
            n_chk++;
            if (d_hs[c] !== m_hs[c]) $display("FAIL rand_hs_ch%0d: got %0d expected %0d", c, d_hs[c], m_hs[c]);
            else n_pass++;
        end
    endtask

    initial begin
        for (int c = 0; c < CH; c++) begin
            m_pend[c] = 0;
            m_ov[c]   = 1'b0;
            m_hs[c]   = 0;
            d_hs[c]   = 0;
            last_chg[c] = 0;
        end
        m_primed = 1'b0;
        m_prev   = '0;
        @(negedge clk);
        test_reset();
        test_single();
        test_backpressure();
        test_saturation();
        test_simultaneous();
        test_reset_ones();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
